accumulator_ctrl: RTL and testbench
===================================

# accumulator_ctrl

Sequencer for `accumulator_bank` that runs one output tile.
- Accepts partial-sum rows from the systolic array over the K-tiles of a tile.
- First K-tile overwrites the bank rows; later K-tiles accumulate into them.
- After the last K-tile, drains each finished row to the downstream stream interface with valid/ready.
- Sits between the array output, the accumulator bank and the post-processing/writeback path.

## Interface
Parameters:
- ARRAY_COL, `ARRAY_COL (16): columns per psum row
- ACC_WIDTH, `ACC_WIDTH (32): bits per accumulator
- ADDR_W, 4: bank row address width (16 rows)
- KT_W, 8: K-tile counter width

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  job start pulse; accepted only in IDLE
- cfg_rows  in  5  rows per K-tile; 0 treated as 1, >16 treated as 16
- cfg_ktiles  in  KT_W  K-tiles per job; 0 treated as 1
- busy  out  1  high in ACCUM and DRAIN
- done  out  1  one-cycle pulse at job completion
- err_drop  out  1  sticky: psum row arrived outside ACCUM
- in_psum_valid  in  1  array psum row valid; no backpressure
- in_psum_vec  in  ARRAY_COL*ACC_WIDTH  psum row
- bank_addr  out  ADDR_W  accumulator bank row address
- bank_wr_en  out  1  bank write enable
- bank_acc_mode  out  1  0 = overwrite, 1 = accumulate
- bank_psum_vec  out  ARRAY_COL*ACC_WIDTH  equals in_psum_vec (pass-through)
- bank_acc_vec  in  ARRAY_COL*ACC_WIDTH  bank asynchronous read data
- out_valid  out  1  drain row valid
- out_ready  in  1  downstream accept
- out_data  out  ARRAY_COL*ACC_WIDTH  drain row data; equals bank_acc_vec
- out_last  out  1  high with the final drain row

## Operation
States: IDLE, ACCUM, DRAIN.
- **Job configuration:** cfg_rows and cfg_ktiles are clamped and latched on the accepted start (as rows_l and kt_l). Config changes mid-job have no effect.
- **IDLE → ACCUM:** on start. Clears the row counter r, the K-tile counter k and err_drop.
- **ACCUM, write controls:** each cycle with in_psum_valid=1:
  - bank_wr_en=1
  - bank_addr=r
  - bank_acc_mode=(k!=0)
- **ACCUM, counter update:** after each accepted row:
  - If r==rows_l-1 then r←0 and k←k+1, else r←r+1.
  - On the last row of the last K-tile (k==kt_l-1), go to DRAIN with r←0.
- **ACCUM, no input:** with in_psum_valid=0, bank_wr_en=0 and the counters hold.
- **DRAIN, outputs:**
  - bank_addr=r, bank_wr_en=0
  - out_valid=1, out_data=bank_acc_vec
  - out_last=(r==rows_l-1)
- **DRAIN, handshake:** on out_valid&&out_ready, r←r+1.
  - On the out_last handshake, go to IDLE and pulse done.
  - With out_ready=0, addr and data hold stable.
- **IDLE outputs:** bank_wr_en=0, out_valid=0, bank_addr=0.
- **Dropped rows:** a row with in_psum_valid=1 in IDLE or DRAIN is not written and sets err_drop.
  - Exception: the start-accept cycle itself is not flagged, because start's clear takes priority.
- **Ignored start:** start while busy is ignored.
- **No stale data:** bank contents are never cleared. Correctness comes from K-tile 0 overwriting every row before any accumulate.
- **Width:** the accumulate add width is owned by the bank; this block performs no arithmetic besides its counters.

## Timing
- **Reset:** all outputs are 0 in the cycle after rst_n is sampled low. State → IDLE and counters → 0.
  - Reset mid-job abandons the job; no done pulse is produced.
- **Write path:** combinational from in_psum_valid. The bank captures on the same rising edge, so the write takes 0 cycles of added latency.
- **Entering DRAIN:** DRAIN begins the cycle after the final accumulate write. out_valid is high in that cycle and shows the updated row 0.
- **Drain rate:** one row per handshake cycle. Minimum drain takes rows_l cycles.
- **Job completion:** done is registered and high for exactly 1 cycle, the cycle after the last handshake. busy is low in that cycle.
  - A start in the done cycle is accepted.
- **Minimum job length:** rows_l*kt_l input cycles plus rows_l drain cycles, plus 1 cycle for done.

## Test plan
- **Single tile:** cfg_rows=4, cfg_ktiles=1; rows of 10,20,30,40 in every column → bank writes with acc_mode=0. Drain outputs 10,20,30,40, out_last on the 4th row, then a single done pulse.
- **Accumulate:** cfg_rows=2, cfg_ktiles=3; each K-tile sends 100 (row 0) and 1 (row 1) → acc_mode is 0,0,1,1,1,1. Drain yields 300 and 3.
- **Backpressure and gaps:**
  - Input in_psum_valid gaps of 1-3 cycles → counters hold.
  - out_ready toggled 0/1 in DRAIN → out_data and bank_addr stable while stalled; no row skipped or duplicated.
- **Clamp and stale data:**
  - cfg_rows=0 → one row; cfg_rows=20 → 16 rows with addr wrapping 0..15.
  - cfg_ktiles=0 → one K-tile. A second job over the same rows with new data overwrites the stale values.
- **Error and ignore:**
  - in_psum_valid during DRAIN → err_drop=1, bank not written.
  - start during ACCUM → ignored.
  - The next accepted start clears err_drop.
- **Mid-job reset:** rst_n low in the middle of ACCUM → all outputs 0 and no done. A new job then completes with correct sums.

Source files
------------

// File: rtl/accumulator_ctrl_if.sv
// Array psum input, accumulator bank port and drain stream bundled for accumulator_ctrl.
// master = the sequencer side, slave = the array/bank/writeback side.
interface accumulator_ctrl_if #(
  parameter int unsigned ARRAY_COL = 16,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned ADDR_W    = 4
);
  localparam int unsigned VEC_W = ARRAY_COL * ACC_WIDTH;

  logic              in_psum_valid;
  logic [VEC_W-1:0]  in_psum_vec;

  logic [ADDR_W-1:0] bank_addr;
  logic              bank_wr_en;
  logic              bank_acc_mode;
  logic [VEC_W-1:0]  bank_psum_vec;
  logic [VEC_W-1:0]  bank_acc_vec;

  logic              out_valid;
  logic              out_ready;
  logic [VEC_W-1:0]  out_data;
  logic              out_last;

  modport master (
    input  in_psum_valid, in_psum_vec, bank_acc_vec, out_ready,
    output bank_addr, bank_wr_en, bank_acc_mode, bank_psum_vec,
           out_valid, out_data, out_last
  );

  modport slave (
    output in_psum_valid, in_psum_vec, bank_acc_vec, out_ready,
    input  bank_addr, bank_wr_en, bank_acc_mode, bank_psum_vec,
           out_valid, out_data, out_last
  );
endinterface

// File: rtl/accumulator_ctrl.sv
// Sequences one output tile: overwrites then accumulates psum rows into the bank
// over all K-tiles, then drains the finished rows on a valid/ready stream.
module accumulator_ctrl #(
  parameter int unsigned ARRAY_COL = 16,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned KT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4:0]        cfg_rows,
  input  logic [KT_W-1:0]   cfg_ktiles,
  output logic              busy,
  output logic              done,
  output logic              err_drop,
  accumulator_ctrl_if.master bus
);

  localparam int unsigned VEC_W    = ARRAY_COL * ACC_WIDTH;
  localparam int unsigned ROWS_W   = ADDR_W + 1;
  localparam int unsigned MAX_ROWS = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_row;
  logic [KT_W-1:0]   r_kt;
  logic [ROWS_W-1:0] r_rows_l;
  logic [KT_W-1:0]   r_kt_l;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_out_valid;
  logic              r_out_last;

  logic [ROWS_W-1:0] w_rows_cl;
  logic [KT_W-1:0]   w_kt_cl;
  logic              w_row_last;
  logic              w_kt_last;
  logic              w_next_last;
  logic              w_wr_en;
  logic [VEC_W-1:0]  w_drain_data;

  // Job configuration clamp and counter terminal conditions
  always_comb begin
    w_rows_cl = ROWS_W'(cfg_rows);
    if (cfg_rows == 5'd0) begin
      w_rows_cl = ROWS_W'(1);
    end else if (ROWS_W'(cfg_rows) > ROWS_W'(MAX_ROWS)) begin
      w_rows_cl = ROWS_W'(MAX_ROWS);
    end
    w_kt_cl     = (cfg_ktiles == '0) ? KT_W'(1) : cfg_ktiles;
    w_row_last  = (ROWS_W'(r_row) == (r_rows_l - ROWS_W'(1)));
    w_kt_last   = (r_kt == (r_kt_l - KT_W'(1)));
    w_next_last = ((ROWS_W'(r_row) + ROWS_W'(2)) == r_rows_l);
  end

  // Bank write strobe follows the array valid with no added latency
  always_comb begin
    w_wr_en      = 1'b0;
    w_drain_data = '0;
    if (r_state == S_ACCUM) begin
      w_wr_en = bus.in_psum_valid;
    end
    if (r_out_valid) begin
      w_drain_data = bus.bank_acc_vec;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_kt        <= '0;
      r_rows_l    <= '0;
      r_kt_l      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rows_l <= w_rows_cl;
            r_kt_l   <= w_kt_cl;
            r_row    <= '0;
            r_kt     <= '0;
            r_err    <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_ACCUM;
          end else if (bus.in_psum_valid) begin
            r_err <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (bus.in_psum_valid) begin
            if (w_row_last) begin
              r_row <= '0;
              if (w_kt_last) begin
                r_kt        <= '0;
                r_state     <= S_DRAIN;
                r_out_valid <= 1'b1;
                r_out_last  <= (r_rows_l == ROWS_W'(1));
              end else begin
                r_kt <= r_kt + KT_W'(1);
              end
            end else begin
              r_row <= r_row + ADDR_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (bus.in_psum_valid) begin
            r_err <= 1'b1;
          end
          if (bus.out_ready) begin
            if (r_out_last) begin
              r_row       <= '0;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_row      <= r_row + ADDR_W'(1);
              r_out_last <= w_next_last;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy              = r_busy;
  assign done              = r_done;
  assign err_drop          = r_err;
  assign bus.bank_addr     = r_row;
  assign bus.bank_wr_en    = w_wr_en;
  assign bus.bank_acc_mode = (r_state == S_ACCUM) && (r_kt != '0);
  assign bus.bank_psum_vec = bus.in_psum_vec;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_last      = r_out_last;
  assign bus.out_data      = w_drain_data;

endmodule

// File: tb/tb_accumulator_ctrl.sv
// Directed bench for accumulator_ctrl: a bank model answers reads, a job-level
// model predicts every output each cycle, and literal sums pin the model.
module tb_accumulator_ctrl;
  localparam int unsigned AC     = 16;
  localparam int unsigned AW     = 32;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned KT_W   = 8;
  localparam int unsigned VW     = AC * AW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [4:0]      cfg_rows = 5'd0;
  logic [KT_W-1:0] cfg_ktiles = '0;
  logic            busy, done, err_drop;

  accumulator_ctrl_if #(.ARRAY_COL(AC), .ACC_WIDTH(AW), .ADDR_W(ADDR_W)) bus ();

  accumulator_ctrl #(.ARRAY_COL(AC), .ACC_WIDTH(AW), .ADDR_W(ADDR_W), .KT_W(KT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_rows(cfg_rows), .cfg_ktiles(cfg_ktiles),
    .busy(busy), .done(done), .err_drop(err_drop), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [VW-1:0] mkvec(input int unsigned base, input int unsigned step);
    logic [VW-1:0] v;
    for (int c = 0; c < AC; c++) v[c*AW +: AW] = AW'(base + step * c);
    return v;
  endfunction

  function automatic logic [VW-1:0] add_vec(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0] s;
    for (int c = 0; c < AC; c++) s[c*AW +: AW] = a[c*AW +: AW] + b[c*AW +: AW];
    return s;
  endfunction

  // Accumulator bank: async read, write/accumulate on the rising edge, stale contents at start
  logic [VW-1:0] bank_mem [16];
  logic          bank_init = 1'b0;
  always @(posedge clk) begin
    if (!bank_init) begin
      for (int i = 0; i < 16; i++) bank_mem[i] <= mkvec(32'hDEAD0000 + i, 3);
      bank_init <= 1'b1;
    end else if (bus.bank_wr_en) begin
      bank_mem[bus.bank_addr] <= bus.bank_acc_mode ?
          add_vec(bank_mem[bus.bank_addr], bus.bank_psum_vec) : bus.bank_psum_vec;
    end
  end
  assign bus.bank_acc_vec = bank_mem[bus.bank_addr];

  // Job-level model: counts accepted rows and drained rows, keeps the expected row sums
  bit            m_accum = 1'b0, m_drain = 1'b0, m_done = 1'b0, m_err = 1'b0;
  int            m_rows = 1, m_kt = 1, m_n = 0, m_d = 0;
  logic [VW-1:0] exp_sum [16];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_accum <= 1'b0; m_drain <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (!m_accum && !m_drain) begin
        if (start) begin
          m_accum <= 1'b1;
          m_rows  <= (cfg_rows == 0) ? 1 : ((cfg_rows > 16) ? 16 : int'(cfg_rows));
          m_kt    <= (cfg_ktiles == 0) ? 1 : int'(cfg_ktiles);
          m_n     <= 0;
          m_err   <= 1'b0;
        end else if (bus.in_psum_valid) begin
          m_err <= 1'b1;
        end
      end else if (m_accum) begin
        if (bus.in_psum_valid) begin
          exp_sum[m_n % m_rows] <= (m_n < m_rows) ? bus.in_psum_vec
                                   : add_vec(exp_sum[m_n % m_rows], bus.in_psum_vec);
          m_n <= m_n + 1;
          if (m_n + 1 == m_rows * m_kt) begin
            m_accum <= 1'b0; m_drain <= 1'b1; m_d <= 0;
          end
        end
      end else begin
        if (bus.in_psum_valid) m_err <= 1'b1;
        if (bus.out_ready) begin
          if (m_d == m_rows - 1) begin m_drain <= 1'b0; m_done <= 1'b1; end
          else m_d <= m_d + 1;
        end
      end
    end
  end

  logic [AW-1:0] drain_q [$];
  bit            mode_q  [$];
  int            done_cnt = 0;

  // Per-cycle compare against the model, sampled mid-cycle
  always @(negedge clk) begin
    chk("busy", busy, m_accum || m_drain);
    chk("done", done, m_done);
    chk("err_drop", err_drop, m_err);
    chk("wr_en", bus.bank_wr_en, m_accum && bus.in_psum_valid);
    chk("out_valid", bus.out_valid, m_drain);
    chk("out_last", bus.out_last, m_drain && (m_d == m_rows - 1));
    chk("out_data", bus.out_data, m_drain ? exp_sum[m_d] : '0);
    chk("bank_addr", bus.bank_addr, m_accum ? (m_n % m_rows) : (m_drain ? m_d : 0));
    if (m_accum && bus.in_psum_valid) begin
      chk("acc_mode", bus.bank_acc_mode, m_n >= m_rows);
      chk("psum_pass", bus.bank_psum_vec, bus.in_psum_vec);
    end
    if (bus.bank_wr_en) mode_q.push_back(bus.bank_acc_mode);
    if (bus.out_valid && bus.out_ready) drain_q.push_back(bus.out_data[AW-1:0]);
    if (done) done_cnt++;
  end

  function automatic logic [AW-1:0] dq(input int i);
    return (i < drain_q.size()) ? drain_q[i] : 32'hBAD0BAD0;
  endfunction

  function automatic bit mq(input int i);
    return (i < mode_q.size()) ? mode_q[i] : 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_job(input int unsigned rows, input int unsigned kt);
    start = 1'b1; cfg_rows = 5'(rows); cfg_ktiles = KT_W'(kt);
    tick();
    start = 1'b0;
  endtask

  task automatic send_row(input logic [VW-1:0] v, input int gap);
    bus.in_psum_valid = 1'b1; bus.in_psum_vec = v;
    tick();
    bus.in_psum_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (done) begin seen = 1'b1; break; end
    end
    chk(name, seen, 1'b1);
  endtask

  int bd, bm, bdone;
  bit seen;

  initial begin
    bus.in_psum_valid = 1'b0; bus.in_psum_vec = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    rst_n = 1'b1;
    tick();

    // Single tile: four rows, overwrite only
    bd = drain_q.size(); bm = mode_q.size(); bdone = done_cnt;
    start_job(4, 1);
    for (int i = 0; i < 4; i++) send_row(mkvec(10 * (i + 1), 0), 0);
    wait_done("t1_done_seen");
    // Accumulate job started in the done cycle
    start_job(2, 3);
    chk("t1_done_count", done_cnt - bdone, 1);
    for (int i = 0; i < 4; i++) chk("t1_drain", dq(bd + i), 10 * (i + 1));
    chk("t1_drain_count", drain_q.size() - bd, 4);
    for (int i = 0; i < 4; i++) chk("t1_mode", mq(bm + i), 1'b0);
    bd = drain_q.size(); bm = mode_q.size();
    for (int k = 0; k < 3; k++) begin
      send_row(mkvec(100, 0), 0);
      send_row(mkvec(1, 0), 0);
    end
    wait_done("t2_done_seen");
    tick();
    for (int i = 0; i < 6; i++) chk("t2_mode", mq(bm + i), i >= 2);
    chk("t2_drain0", dq(bd), 300);
    chk("t2_drain1", dq(bd + 1), 3);

    // Gaps, ignored start mid-ACCUM, stalled drain with a dropped row
    bd = drain_q.size();
    bus.out_ready = 1'b0;
    start_job(3, 2);
    send_row(mkvec(1000, 1), 2);
    start_job(1, 1);
    send_row(mkvec(2000, 1), 1);
    send_row(mkvec(3000, 1), 3);
    send_row(mkvec(7, 0), 0);
    send_row(mkvec(7, 0), 2);
    send_row(mkvec(7, 0), 0);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      bus.out_ready = (i % 3 == 2);
      bus.in_psum_valid = (i == 1);
      bus.in_psum_vec = mkvec(32'hFFFF, 0);
      tick();
      if (done) seen = 1'b1;
    end
    bus.in_psum_valid = 1'b0; bus.out_ready = 1'b1;
    chk("t3_done_seen", seen, 1'b1);
    chk("t3_err_set", err_drop, 1'b1);
    chk("t3_drain_count", drain_q.size() - bd, 3);
    chk("t3_drain0", dq(bd), 1007);
    chk("t3_drain2", dq(bd + 2), 3007);

    // Clamp: zero config gives one row, one K-tile; next start clears err_drop
    bd = drain_q.size();
    start_job(0, 0);
    chk("t4_err_cleared", err_drop, 1'b0);
    send_row(mkvec(55, 0), 0);
    wait_done("t4_done_seen");
    tick();
    chk("t4_drain_count", drain_q.size() - bd, 1);
    chk("t4_drain0", dq(bd), 55);

    // Clamp: 20 rows become 16, address wraps through the whole bank
    bd = drain_q.size(); bm = mode_q.size();
    start_job(20, 1);
    for (int i = 0; i < 16; i++) send_row(mkvec(500 + i, 0), 0);
    wait_done("t5_done_seen");
    tick();
    chk("t5_drain_count", drain_q.size() - bd, 16);
    chk("t5_drain15", dq(bd + 15), 515);
    chk("t5_mode_count", mode_q.size() - bm, 16);

    // Second job over the same rows overwrites stale sums
    bd = drain_q.size();
    start_job(4, 0);
    for (int i = 0; i < 4; i++) send_row(mkvec(9 - i, 0), 0);
    wait_done("t6_done_seen");
    tick();
    for (int i = 0; i < 4; i++) chk("t6_drain", dq(bd + i), 9 - i);

    // Reset in the middle of ACCUM abandons the job without done
    bdone = done_cnt;
    start_job(4, 2);
    for (int i = 0; i < 3; i++) send_row(mkvec(77, 0), 0);
    rst_n = 1'b0;
    tick();
    chk("t7_busy", busy, 1'b0);
    chk("t7_wr_en", bus.bank_wr_en, 1'b0);
    chk("t7_addr", bus.bank_addr, 0);
    chk("t7_out_valid", bus.out_valid, 1'b0);
    chk("t7_err", err_drop, 1'b0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("t7_no_done", done_cnt - bdone, 0);
    bd = drain_q.size();
    start_job(2, 2);
    send_row(mkvec(5, 0), 0);
    send_row(mkvec(6, 0), 1);
    send_row(mkvec(10, 0), 0);
    send_row(mkvec(20, 0), 0);
    wait_done("t7_done_seen");
    tick();
    chk("t7_drain0", dq(bd), 15);
    chk("t7_drain1", dq(bd + 1), 26);

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
